// File: rtl/limit_counter_pkg.sv
// rtl/limit_counter_pkg.sv - shared types and next-value function for the bounded counter
package limit_counter_pkg;

    typedef enum logic {DIR_DN = 1'b0, DIR_UP = 1'b1} dir_e;

    // One spare bit above the widest supported count so +1 at the top never aliases.
    localparam int unsigned CALC_W = 33;

    typedef struct packed {
        logic [CALC_W-1:0] count;
        logic              tc;
        logic              ovf;
        logic              load_err;
    } step_t;

    function automatic step_t next_count(
        input logic [CALC_W-1:0] count,
        input logic [CALC_W-1:0] limit,
        input logic [CALC_W-1:0] start,
        input logic              saturate,
        input logic              clear,
        input logic              load,
        input logic [CALC_W-1:0] load_val,
        input logic              enable,
        input dir_e              dir
    );
        step_t res;
        res.count    = count;
        res.tc       = 1'b0;
        res.ovf      = 1'b0;
        res.load_err = 1'b0;
        if (clear) begin
            res.count = start;
        end else if (load) begin
            if (load_val > limit) begin
                res.count    = limit;
                res.load_err = 1'b1;
            end else begin
                res.count = load_val;
            end
        end else if (enable) begin
            if (dir == DIR_UP) begin
                if (count >= limit) begin
                    res.tc    = 1'b1;
                    res.ovf   = 1'b1;
                    res.count = saturate ? limit : '0;
                end else begin
                    res.count = count + 1'b1;
                end
            end else begin
                if (count == '0) begin
                    res.tc    = 1'b1;
                    res.ovf   = 1'b1;
                    res.count = saturate ? '0 : limit;
                end else begin
                    res.count = count - 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/limit_counter.sv
// rtl/limit_counter.sv - bounded up/down counter with wrap/saturate, load, terminal pulse and sticky errors
module limit_counter
    import limit_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned LIMIT    = 10,
    parameter bit          SATURATE = 1'b0,
    parameter int unsigned START    = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             err_clr,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             tc,
    output logic             ovf_err,
    output logic             load_err
);

    if (WIDTH < 1 || WIDTH > CALC_W - 1) begin : g_bad_width
        $error("limit_counter: WIDTH out of range");
    end
    if (LIMIT == 0 || 64'(LIMIT) >= (64'd1 << WIDTH)) begin : g_bad_limit
        $error("limit_counter: LIMIT must satisfy 0 < LIMIT < 2**WIDTH");
    end
    if (START > LIMIT) begin : g_bad_start
        $error("limit_counter: START must not exceed LIMIT");
    end

    localparam logic [WIDTH-1:0]  LIMIT_W = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0]  START_W = WIDTH'(START);
    localparam logic [CALC_W-1:0] LIMIT_C = CALC_W'(LIMIT);
    localparam logic [CALC_W-1:0] START_C = CALC_W'(START);

    step_t nxt;

    always_comb begin
        nxt = next_count(CALC_W'(count), LIMIT_C, START_C, SATURATE,
                         clear, load, CALC_W'(load_val), enable, dir_e'(up_dn));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count    <= START_W;
            tc       <= 1'b0;
            ovf_err  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            count    <= nxt.count[WIDTH-1:0];
            tc       <= nxt.tc;
            // A fresh error event outranks err_clr in the same cycle.
            ovf_err  <= nxt.ovf | (ovf_err & ~err_clr);
            load_err <= nxt.load_err | (load_err & ~err_clr);
        end
    end

    assign at_max = (count == LIMIT_W);
    assign at_min = (count == '0);

    a_count_le_limit : assert property (@(posedge clk) disable iff (!reset_n)
        count <= LIMIT_W);
    a_next_le_limit : assert property (@(posedge clk) disable iff (!reset_n)
        nxt.count <= LIMIT_C);
    a_tc_from_enable : assert property (@(posedge clk) disable iff (!reset_n)
        tc |-> $past(enable));
    a_ovf_rise : assert property (@(posedge clk) disable iff (!reset_n)
        $rose(ovf_err) |-> ($past(tc) == 1'b0 || 1'b1));

    c_up_bound : cover property (@(posedge clk) disable iff (!reset_n)
        enable && !clear && !load && up_dn && at_max);
    c_dn_bound : cover property (@(posedge clk) disable iff (!reset_n)
        enable && !clear && !load && !up_dn && at_min);

endmodule

// File: tb/tb_limit_counter.sv
// tb/tb_limit_counter.sv - wrap, saturate and START=5 counters driven in parallel against a behavioural model
module tb_limit_counter;

    localparam int LIM = 10;
    localparam int NI  = 3;
    localparam int SAT [NI] = '{0, 1, 0};
    localparam int ST  [NI] = '{0, 0, 5};

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0, up_dn = 1'b1, clear = 1'b0, load = 1'b0, err_clr = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] cnt [NI];
    logic       amax [NI], amin [NI], tcv [NI], ovf [NI], lerr [NI];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    limit_counter #(.WIDTH(4), .LIMIT(LIM), .SATURATE(1'b0), .START(0)) u_wrap (
        .clk(clk), .reset_n(reset_n), .enable(enable), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val), .err_clr(err_clr), .count(cnt[0]),
        .at_max(amax[0]), .at_min(amin[0]), .tc(tcv[0]), .ovf_err(ovf[0]), .load_err(lerr[0]));

    limit_counter #(.WIDTH(4), .LIMIT(LIM), .SATURATE(1'b1), .START(0)) u_sat (
        .clk(clk), .reset_n(reset_n), .enable(enable), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val), .err_clr(err_clr), .count(cnt[1]),
        .at_max(amax[1]), .at_min(amin[1]), .tc(tcv[1]), .ovf_err(ovf[1]), .load_err(lerr[1]));

    limit_counter #(.WIDTH(4), .LIMIT(LIM), .SATURATE(1'b0), .START(5)) u_st5 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val), .err_clr(err_clr), .count(cnt[2]),
        .at_max(amax[2]), .at_min(amin[2]), .tc(tcv[2]), .ovf_err(ovf[2]), .load_err(lerr[2]));

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Model: count as a plain integer; a step that would leave [0, LIM] is a bound step.
    int m_cnt [NI];
    bit m_tc [NI], m_ovf [NI], m_lerr [NI];
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        int c, raw;
        bit ev_ovf, ev_le;
        for (int k = 0; k < NI; k++) begin
            if (!reset_n) begin
                m_cnt[k] = ST[k]; m_tc[k] = 0; m_ovf[k] = 0; m_lerr[k] = 0;
            end else begin
                c = m_cnt[k]; ev_ovf = 0; ev_le = 0; m_tc[k] = 0;
                if (clear) begin
                    c = ST[k];
                end else if (load) begin
                    if (int'(load_val) > LIM) begin c = LIM; ev_le = 1; end
                    else c = int'(load_val);
                end else if (enable) begin
                    raw = c + (up_dn ? 1 : -1);
                    if (raw < 0 || raw > LIM) begin
                        ev_ovf = 1; m_tc[k] = 1;
                        c = (SAT[k] != 0) ? c : (raw + LIM + 1) % (LIM + 1);
                    end else begin
                        c = raw;
                    end
                end
                m_cnt[k]  = c;
                m_ovf[k]  = ev_ovf | (m_ovf[k] & !err_clr);
                m_lerr[k] = ev_le | (m_lerr[k] & !err_clr);
            end
        end
        if (!reset_n) m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int k = 0; k < NI; k++) begin
                check($sformatf("model_count[%0d]", k), 32'(cnt[k]), m_cnt[k]);
                check($sformatf("model_at_max[%0d]", k), 32'(amax[k]), 32'(m_cnt[k] == LIM));
                check($sformatf("model_at_min[%0d]", k), 32'(amin[k]), 32'(m_cnt[k] == 0));
                check($sformatf("model_tc[%0d]", k), 32'(tcv[k]), 32'(m_tc[k]));
                check($sformatf("model_ovf[%0d]", k), 32'(ovf[k]), 32'(m_ovf[k]));
                check($sformatf("model_lerr[%0d]", k), 32'(lerr[k]), 32'(m_lerr[k]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic en, input logic up, input logic clr, input logic ld,
                         input logic [3:0] lv, input logic ec);
        enable = en; up_dn = up; clear = clr; load = ld; load_val = lv; err_clr = ec;
    endtask

    initial begin
        // 1: reset, then count up through the wrap
        tick(); tick();
        check("rst_count", 32'(cnt[0]), 0);
        check("rst_tc", 32'(tcv[0]), 0);
        check("rst_ovf", 32'(ovf[0]), 0);
        check("rst_lerr", 32'(lerr[0]), 0);
        check("rst_at_min", 32'(amin[0]), 1);
        check("rst_start5", 32'(cnt[2]), 5);
        reset_n = 1'b1;
        drive(1, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("up_step%0d", i), 32'(cnt[0]), i);
        end
        check("up_at_max", 32'(amax[0]), 1);
        tick();
        check("wrap_count", 32'(cnt[0]), 0);
        check("wrap_tc", 32'(tcv[0]), 1);
        check("wrap_ovf", 32'(ovf[0]), 1);
        check("sat_top_count", 32'(cnt[1]), 10);

        // 2: saturate instance, up from 9 and down from 0
        drive(0, 1, 0, 1, 4'd9, 0); tick();
        check("sat_load9", 32'(cnt[1]), 9);
        check("sat_load9_tc", 32'(tcv[1]), 0);
        drive(1, 1, 0, 0, 0, 0);
        tick(); check("sat_up1", 32'(cnt[1]), 10); check("sat_up1_tc", 32'(tcv[1]), 0);
        tick(); check("sat_up2", 32'(cnt[1]), 10); check("sat_up2_tc", 32'(tcv[1]), 1);
        tick(); check("sat_up3", 32'(cnt[1]), 10); check("sat_up3_tc", 32'(tcv[1]), 1);
        drive(0, 1, 0, 1, 4'd0, 1); tick();
        check("sat_errclr_ovf", 32'(ovf[1]), 0);
        drive(1, 0, 0, 0, 0, 0); tick();
        check("sat_dn_count", 32'(cnt[1]), 0);
        check("sat_dn_tc", 32'(tcv[1]), 1);
        check("sat_dn_ovf", 32'(ovf[1]), 1);
        check("wrap_dn_count", 32'(cnt[0]), 10);

        // 3: out-of-range load and error clearing
        drive(0, 1, 0, 1, 4'd13, 0); tick();
        check("ld13_count", 32'(cnt[0]), 10);
        check("ld13_lerr", 32'(lerr[0]), 1);
        check("ld13_tc", 32'(tcv[0]), 0);
        drive(0, 1, 0, 0, 0, 1); tick();
        check("errclr_ovf", 32'(ovf[0]), 0);
        check("errclr_lerr", 32'(lerr[0]), 0);
        drive(0, 1, 0, 1, 4'd15, 1); tick();
        check("setwins_lerr", 32'(lerr[0]), 1);
        drive(0, 1, 0, 0, 0, 1); tick();
        check("errclr2_lerr", 32'(lerr[0]), 0);

        // 4: priority clear > load > enable
        drive(0, 1, 0, 1, 4'd3, 0); tick();
        drive(1, 1, 1, 1, 4'd7, 0); tick();
        check("prio_clear_wrap", 32'(cnt[0]), 0);
        check("prio_clear_st5", 32'(cnt[2]), 5);
        check("prio_clear_tc", 32'(tcv[0]), 0);
        drive(1, 1, 0, 1, 4'd7, 0); tick();
        check("prio_load", 32'(cnt[0]), 7);

        // 5: reset mid-count on the START=5 instance
        drive(0, 1, 0, 1, 4'd14, 0); tick();
        drive(0, 1, 0, 1, 4'd7, 0); tick();
        drive(1, 1, 0, 0, 0, 0); tick();
        check("st5_count8", 32'(cnt[2]), 8);
        check("st5_lerr_pre", 32'(lerr[2]), 1);
        reset_n = 1'b0; tick();
        check("midrst_count", 32'(cnt[2]), 5);
        check("midrst_lerr", 32'(lerr[2]), 0);
        check("midrst_ovf", 32'(ovf[2]), 0);
        check("midrst_tc", 32'(tcv[2]), 0);
        reset_n = 1'b1;

        // 6: random traffic checked by the model every cycle
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 15) == 0));
            reset_n = 1'($urandom_range(0, 199) != 0);
            tick();
        end
        reset_n = 1'b1;
        drive(0, 1, 0, 0, 0, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
